// File: rtl/spi_avalon_master.sv
// spi_avalon_master
//   Mode-0 SPI slave that turns register frames from the ESP32 (NINA module)
//   into single Avalon-MM reads and writes. The SPI pins are oversampled in the
//   system clock domain, so no logic runs on the SPI clock.
//
//   Frame (MSB first): CMD[7:0] (bit7=1 write), ADDR[ADDR_W-1:0],
//   one dummy byte (reads only), DATA[DATA_W-1:0].
//
// Ports
//   clock, reset          system clock; synchronous active-low reset
//   spi_sclk/cs_n/mosi    asynchronous SPI inputs (sclk <= clock/8)
//   spi_miso              SPI data out, 0 outside the read data phase
//   avm_*                 Avalon-MM master (registered request fields)
//   busy                  frame in progress or its Avalon transfer pending
//   err_timeout           sticky waitrequest timeout flag
module spi_avalon_master #(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       TIMEOUT     = 255,
    parameter logic [DATA_W-1:0] ERR_WORD    = 32'hDEADBEEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              err_timeout
);

    localparam int unsigned SH_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned RD_BITS = 8 + ADDR_W + 8 + DATA_W;
    localparam int unsigned CNT_W   = $clog2(RD_BITS + 1);
    localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CMD_END   = CNT_W'(8);
    localparam logic [CNT_W-1:0] ADDR_END  = CNT_W'(8 + ADDR_W);
    localparam logic [CNT_W-1:0] WR_END    = CNT_W'(8 + ADDR_W + DATA_W);
    localparam logic [CNT_W-1:0] DUMMY_END = CNT_W'(8 + ADDR_W + 8);
    localparam logic [CNT_W-1:0] RD_END    = CNT_W'(RD_BITS);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, WDATA, WR_REQ, RD_REQ, DUMMY, RDATA, DONE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall;

    logic [CNT_W-1:0]  bit_cnt, bit_inc;
    logic [SH_W-2:0]   shift_in;
    logic [DATA_W-1:0] miso_shift;
    logic [TO_W-1:0]   tcnt;
    logic              is_write;
    logic              strobe, req_ok, req_to, req_end;
    logic              counting, issue_rd, issue_wr, addr_load;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection on the synchronised samples
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    assign bit_inc = bit_cnt + CNT_W'(1);

    // ------------------------------------------------------------------
    // Avalon request completion
    // ------------------------------------------------------------------
    assign strobe  = avm_read | avm_write;
    assign req_ok  = strobe & ~avm_waitrequest;
    assign req_to  = strobe & avm_waitrequest & (tcnt == TO_LAST);
    assign req_end = req_ok | req_to;

    // ------------------------------------------------------------------
    // Frame FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (cs_fall) state_next = CMD;
            CMD: begin
                if (cs_s) state_next = IDLE;
                else if (sclk_rise && bit_inc == CMD_END) state_next = ADDR;
            end
            ADDR: begin
                if (cs_s) state_next = IDLE;
                else if (sclk_rise && bit_inc == ADDR_END)
                    state_next = is_write ? WDATA : RD_REQ;
            end
            WDATA: begin
                if (cs_s) state_next = IDLE;
                else if (sclk_rise && bit_inc == WR_END) state_next = WR_REQ;
            end
            // An issued request always runs to completion or timeout,
            // whatever CS does meanwhile.
            WR_REQ: if (req_end) state_next = DONE;
            // Dummy sclk cycles keep counting here while the read is pending.
            RD_REQ: if (req_end) state_next = DUMMY;
            DUMMY: begin
                if (cs_s) state_next = IDLE;
                else if (bit_cnt >= DUMMY_END) state_next = RDATA;
            end
            RDATA: begin
                if (cs_s) state_next = IDLE;
                else if (sclk_rise && bit_inc == RD_END) state_next = DONE;
            end
            DONE:   if (cs_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign counting  = state inside {CMD, ADDR, WDATA, RD_REQ, DUMMY, RDATA};
    assign addr_load = (state == ADDR) && (state_next == WDATA || state_next == RD_REQ);
    assign issue_rd  = (state == ADDR) && (state_next == RD_REQ);
    assign issue_wr  = (state == WDATA) && (state_next == WR_REQ);

    // ------------------------------------------------------------------
    // Registered state, shifters and Avalon request
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            bit_cnt       <= '0;
            shift_in      <= '0;
            miso_shift    <= '0;
            is_write      <= 1'b0;
            tcnt          <= '0;
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state != IDLE);

            if (state == IDLE)
                bit_cnt <= '0;
            else if (counting && sclk_rise && bit_cnt != RD_END)
                bit_cnt <= bit_inc;

            if (sclk_rise && (state == CMD || state == ADDR || state == WDATA))
                shift_in <= {shift_in[SH_W-3:0], mosi_s};

            if (state == CMD && sclk_rise && bit_cnt == '0)
                is_write <= mosi_s;

            if (addr_load)
                avm_address <= {shift_in[ADDR_W-2:0], mosi_s};

            if (issue_rd) begin
                avm_read <= 1'b1;
                tcnt     <= '0;
            end

            if (issue_wr) begin
                avm_writedata <= {shift_in[DATA_W-2:0], mosi_s};
                avm_write     <= 1'b1;
                err_timeout   <= 1'b0;
                tcnt          <= '0;
            end

            if (req_ok) begin
                avm_read  <= 1'b0;
                avm_write <= 1'b0;
                if (avm_read)
                    miso_shift <= avm_readdata;
            end else if (req_to) begin
                avm_read    <= 1'b0;
                avm_write   <= 1'b0;
                err_timeout <= 1'b1;
                if (avm_read)
                    miso_shift <= ERR_WORD;
            end else if (strobe) begin
                tcnt <= tcnt + TO_W'(1);
            end

            // The falling edge that follows the last dummy bit must not
            // shift: the MSB has to stay on MISO for the first data bit.
            if (state == RDATA && sclk_fall && bit_cnt > DUMMY_END)
                miso_shift <= {miso_shift[DATA_W-2:0], 1'b0};
        end
    end

    assign spi_miso = (state == RDATA) ? miso_shift[DATA_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_avalon_master.sv
// Testbench for spi_avalon_master: directed SPI frames with a scoreboard for
// Avalon transfers and MISO words, plus direct checks of flags and timing.
module tb_spi_avalon_master;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [15:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        err_timeout;

    logic [31:0] rd_value = 32'h0;
    int unsigned stall_n = 0;
    int unsigned stall_cnt = 0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
    } av_t;

    av_t         av_exp[$];
    logic [63:0] miso_exp[$];
    logic [63:0] miso_got[$];

    int unsigned cur_len = 0;
    int unsigned last_len = 0;
    int unsigned strobe_total = 0;

    always #5 clock = ~clock;

    spi_avalon_master #(
        .ADDR_W(16),
        .DATA_W(32),
        .SYNC_STAGES(2),
        .TIMEOUT(255),
        .ERR_WORD(32'hDEADBEEF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .spi_sclk(spi_sclk),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    // Slave model: stalls the first stall_n cycles of each request.
    assign avm_waitrequest = (avm_read | avm_write) && (stall_cnt < stall_n);
    assign avm_readdata    = rd_value;

    always @(posedge clock)
        stall_cnt <= (avm_read | avm_write) ? stall_cnt + 1 : 0;

    // Strobe length measurement.
    always @(negedge clock) begin
        if (avm_read | avm_write) begin
            cur_len++;
            strobe_total++;
        end else if (cur_len != 0) begin
            last_len = cur_len;
            cur_len = 0;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Avalon monitor: every accepted transfer is matched against the queue.
    always @(negedge clock) begin
        if (reset && (avm_read | avm_write) && !avm_waitrequest) begin
            av_t got;
            got = '{wr: avm_write, addr: avm_address,
                    data: avm_write ? avm_writedata : 32'h0};
            if (av_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL avalon_unexpected: got %h expected none", got);
            end else begin
                check("avalon_transfer", 64'(got), 64'(av_exp.pop_front()));
            end
        end
    end

    // MISO monitor: each completed frame's sampled MISO bits.
    always @(negedge clock) begin
        while (miso_got.size() != 0 && miso_exp.size() != 0)
            check("miso_word", miso_got.pop_front(), miso_exp.pop_front());
    end

    task automatic wait_strobe_low();
        for (int k = 0; k < 400 && (avm_read | avm_write); k++)
            @(negedge clock);
        check("strobe_release_bound", 64'(avm_read | avm_write), 64'd0);
    endtask

    // Shift n bits of tx (MSB first), sampling MISO just before each rising
    // sclk. After bit pause_at the bench waits for the pending request.
    task automatic spi_bits(input logic [63:0] tx, input int unsigned n,
                            input int unsigned pause_at, output logic [63:0] rx);
        rx = '0;
        for (int unsigned i = 0; i < n; i++) begin
            spi_sclk = 1'b0;
            spi_mosi = tx[n-1-i];
            repeat (4) @(negedge clock);
            rx = {rx[62:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (4) @(negedge clock);
            if (i + 1 == pause_at)
                wait_strobe_low();
        end
        spi_sclk = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic frame(input logic [63:0] tx, input int unsigned n,
                         input int unsigned pause_at, input logic [63:0] miso_e,
                         input int unsigned gap);
        logic [63:0] rx;
        miso_exp.push_back(miso_e);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clock);
        spi_bits(tx, n, pause_at, rx);
        spi_cs_n = 1'b1;
        miso_got.push_back(rx);
        repeat (gap) @(negedge clock);
    endtask

    task automatic write_frame(input logic [15:0] a, input logic [31:0] d, input int unsigned gap);
        av_exp.push_back('{wr: 1'b1, addr: a, data: d});
        frame({8'h00, 8'h80, a, d}, 56, 0, 64'd0, gap);
    endtask

    initial begin
        logic [63:0] rx;
        int unsigned snap;

        // Reset state
        repeat (4) @(negedge clock);
        check("rst_avm_read", 64'(avm_read), 64'd0);
        check("rst_avm_write", 64'(avm_write), 64'd0);
        check("rst_avm_address", 64'(avm_address), 64'd0);
        check("rst_avm_writedata", 64'(avm_writedata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        check("rst_miso", 64'(spi_miso), 64'd0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        // 1: plain write, no stall
        stall_n = 0;
        write_frame(16'h0100, 32'hDEADBEEF, 8);
        check("t1_write_len", 64'(last_len), 64'd1);
        check("t1_err", 64'(err_timeout), 64'd0);
        check("t1_busy_idle", 64'(busy), 64'd0);

        // 2: read with one stall cycle
        stall_n = 1;
        rd_value = 32'h00000014;
        av_exp.push_back('{wr: 1'b0, addr: 16'h0000, data: 32'h0});
        frame({8'h00, 16'h0000, 8'h00, 32'h0}, 64, 0, {32'h0, 32'h00000014}, 8);
        check("t2_read_len", 64'(last_len), 64'd2);

        // 3: read timing out, then a write clearing the flag
        stall_n = 1000;
        rd_value = 32'h11111111;
        frame({8'h00, 16'h0500, 8'h00, 32'h0}, 64, 32, {32'h0, 32'hDEADBEEF}, 8);
        check("t3_timeout_len", 64'(last_len), 64'd255);
        check("t3_err_set", 64'(err_timeout), 64'd1);
        stall_n = 0;
        write_frame(16'h0600, 32'h0BADF00D, 8);
        check("t3_err_cleared", 64'(err_timeout), 64'd0);

        // 4: CS rises after 20 bits, then a clean write
        snap = strobe_total;
        frame(64'({8'h80, 16'h0300, 32'hCAFEF00D}) >> 36, 20, 0, 64'd0, 8);
        repeat (4) @(negedge clock);
        check("t4_no_strobe", 64'(strobe_total), 64'(snap));
        check("t4_idle", 64'(busy), 64'd0);
        write_frame(16'h0200, 32'h12345678, 8);

        // 5: reset while a write is stalled
        stall_n = 1000;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clock);
        spi_bits({8'h00, 8'h80, 16'h0400, 32'h55AA55AA}, 56, 0, rx);
        for (int k = 0; k < 50 && !avm_write; k++) @(negedge clock);
        check("t5_write_pending", 64'(avm_write), 64'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("t5_rst_strobes", 64'({avm_read, avm_write}), 64'd0);
        check("t5_rst_address", 64'(avm_address), 64'd0);
        check("t5_rst_writedata", 64'(avm_writedata), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_miso_err", 64'({spi_miso, err_timeout}), 64'd0);
        @(negedge clock);
        spi_cs_n = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        stall_n = 0;
        repeat (4) @(negedge clock);
        check("t5_idle_after", 64'(busy), 64'd0);

        // 6: back-to-back writes with a 4-clock CS gap
        write_frame(16'h0700, 32'h01234567, 4);
        write_frame(16'h0701, 32'h89ABCDEF, 8);

        repeat (20) @(negedge clock);
        check("av_queue_drained", 64'(av_exp.size()), 64'd0);
        check("miso_queue_drained", 64'(miso_exp.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
